// File: rtl/adc_capture_ring.sv
// adc_capture_ring
// ----------------
// Ring-buffer capture of ADC samples around a trigger. After arm, the block
// fills PRETRIG samples of history, then keeps overwriting the ring until a
// qualified trigger. After the trigger it records DEPTH-PRETRIG samples,
// counting the trigger sample itself. It then streams the whole ring out,
// oldest sample first.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   arm               start a capture (honoured in IDLE only)
//   abort             return to IDLE on the next cycle, from any state
//   adc_valid/data    incoming sample stream (no backpressure)
//   trig              trigger qualifier, only meaningful with adc_valid
//   busy              high whenever the FSM is not IDLE
//   done              one-cycle pulse after the final readout handshake
//   trig_addr         RAM address of the trigger sample
//   rd_valid/ready    readout handshake
//   rd_data/rd_last   readout word, rd_last marks the DEPTH-th word
//   state_dbg         current FSM state encoding
//
// Readout handshake: a word transfers on every rising edge where rd_valid
// and rd_ready are both high. Once rd_valid is raised, it stays high and
// rd_data/rd_last hold their values until that transfer happens. rd_ready
// may change freely and never influences rd_valid in the same cycle.
module adc_capture_ring #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 13,
    parameter int PRETRIG = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              trig,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [2:0]        state_dbg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PRE_C   = (ADDR_W+1)'(PRETRIG);
    localparam logic [ADDR_W:0] POST_C  = (ADDR_W+1)'(DEPTH - PRETRIG);
    localparam bit PRE_ZERO = (PRETRIG == 0);
    localparam bit POST_ONE = ((DEPTH - PRETRIG) == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    // Readout pipeline: one RAM read in flight (pend), a skid slot, and the
    // output register. This gives at most two words of storage.
    logic              pend;
    logic              pend_last;
    logic              sk_valid;
    logic [DATA_W-1:0] sk_data;
    logic              sk_last;

    logic              wr_en;
    logic              rd_en;
    logic              pop;
    logic [1:0]        occ;
    logic [1:0]        occ_after;

    assign cnt_inc   = cnt + 1'b1;
    assign pop       = rd_valid & rd_ready;
    assign state_dbg = state;

    assign wr_en = !abort && adc_valid &&
                   (state == S_FILL || state == S_ARMED || state == S_POST);

    // Issue a read only if the word it returns is sure to find a free slot
    // next cycle. This keeps one read per cycle under a steady rd_ready,
    // and keeps the pipeline from overflowing when rd_ready stalls.
    assign occ       = {1'b0, rd_valid} + {1'b0, sk_valid} + {1'b0, pend};
    assign occ_after = occ - {1'b0, pop};
    assign rd_en     = !abort && (state == S_READ) && (cnt != DEPTH_C) &&
                       (occ_after < 2'd2);

    // Single-port RAM: wp addresses both writes and reads; the two never
    // coincide because writes stop before READ.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= adc_data;
        end else if (rd_en) begin
            ram_q <= mem[wp];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wp        <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_last   <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                rd_valid  <= 1'b0;
                rd_last   <= 1'b0;
                sk_valid  <= 1'b0;
                pend      <= 1'b0;
                pend_last <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state     <= PRE_ZERO ? S_ARMED : S_FILL;
                            wp        <= '0;
                            cnt       <= '0;
                            trig_addr <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (adc_valid) begin
                            wp  <= wp + 1'b1;
                            cnt <= cnt_inc;
                            if (cnt_inc == PRE_C) state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (adc_valid) begin
                            wp <= wp + 1'b1;
                            if (trig) begin
                                trig_addr <= wp;
                                // The trigger sample already counts as the
                                // first post-trigger write.
                                cnt   <= POST_ONE ? '0 : (ADDR_W+1)'(1);
                                state <= POST_ONE ? S_READ : S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (adc_valid) begin
                            wp <= wp + 1'b1;
                            if (cnt_inc == POST_C) begin
                                state <= S_READ;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    S_READ: begin
                        // wp now points at the oldest sample; cnt counts
                        // issued reads.
                        if (rd_en) begin
                            wp  <= wp + 1'b1;
                            cnt <= cnt_inc;
                        end
                        pend      <= rd_en;
                        pend_last <= rd_en && (cnt_inc == DEPTH_C);

                        if (pop || !rd_valid) begin
                            if (sk_valid) begin
                                rd_valid <= 1'b1;
                                rd_data  <= sk_data;
                                rd_last  <= sk_last;
                                sk_valid <= pend;
                                sk_data  <= ram_q;
                                sk_last  <= pend_last;
                            end else if (pend) begin
                                rd_valid <= 1'b1;
                                rd_data  <= ram_q;
                                rd_last  <= pend_last;
                            end else begin
                                rd_valid <= 1'b0;
                                rd_last  <= 1'b0;
                            end
                        end else if (pend) begin
                            sk_valid <= 1'b1;
                            sk_data  <= ram_q;
                            sk_last  <= pend_last;
                        end

                        if (pop && rd_last) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            sk_valid <= 1'b0;
                            pend     <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ring.sv
// tb_adc_capture_ring
// Bench for adc_capture_ring with DEPTH=16 and PRETRIG=4. The reference
// model records every sample presented with adc_valid after arm. It takes
// the first trigger at sample index >= PRETRIG. It predicts the frame as
// samples[t-PRETRIG .. t+DEPTH-PRETRIG-1] and the trigger address as
// t mod DEPTH.
module tb_adc_capture_ring;

    localparam int DATA_W  = 10;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int PRETRIG = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              adc_valid = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              trig = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [2:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid_cyc = 0;

    logic [DATA_W-1:0] smp_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    bit                trg_q[$];
    bit                last_q[$];
    int                cyc_q[$];
    int                trig_list[$];

    adc_capture_ring #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .abort     (abort),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .trig_addr (trig_addr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic bit is_trig(input int idx);
        foreach (trig_list[i]) if (trig_list[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_frame();
        int t;
        t = -1;
        exp_q.delete();
        for (int i = PRETRIG; i < trg_q.size(); i++) begin
            if (trg_q[i]) begin
                t = i;
                break;
            end
        end
        if (t >= 0)
            for (int k = t - PRETRIG; k < t + DEPTH - PRETRIG && k < smp_q.size(); k++)
                exp_q.push_back(smp_q[k]);
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_arm();
        arm = 1'b1;
        adc_valid = 1'b0;
        trig = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic feed(input int base, input int gap, input bit rnd_data, input bit noise,
                        input int max_smp, output bit saw_valid);
        int idx;
        int k;
        idx = 0;
        k = 0;
        saw_valid = 1'b0;
        smp_q.delete();
        trg_q.delete();
        cyc_q.delete();
        for (int n = 0; n < 600; n++) begin
            if (rd_valid) begin
                saw_valid = 1'b1;
                first_valid_cyc = cyc;
                break;
            end
            if (max_smp > 0 && idx >= max_smp) break;
            if (k % gap == 0) begin
                adc_valid = 1'b1;
                adc_data  = rnd_data ? DATA_W'($urandom) : DATA_W'(base + idx);
                trig      = is_trig(idx);
                smp_q.push_back(adc_data);
                trg_q.push_back(trig);
                cyc_q.push_back(cyc);
                idx++;
            end else begin
                adc_valid = 1'b0;
                adc_data  = DATA_W'($urandom);
                trig      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            k++;
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
        trig = 1'b0;
    endtask

    // Collects handshaked words into got_q/last_q; stall_bad counts cycles
    // where a stalled word changed; span is first-to-last handshake cycles.
    task automatic drain(input bit rnd_ready, input int max_pops, output bit got_last,
                         output int stall_bad, output int span);
        logic pv, pr, pl;
        logic [DATA_W-1:0] pd;
        int first_pop, last_pop;
        got_q.delete();
        last_q.delete();
        got_last = 1'b0;
        stall_bad = 0;
        span = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        first_pop = -1;
        last_pop = -1;
        for (int n = 0; n < 400; n++) begin
            if (pv && !pr && (!rd_valid || rd_data !== pd || rd_last !== pl)) stall_bad++;
            if (max_pops > 0 && got_q.size() >= max_pops) break;
            rd_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            adc_valid = 1'($urandom_range(0, 1));
            adc_data  = DATA_W'($urandom);
            trig      = 1'($urandom_range(0, 1));
            pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                last_q.push_back(rd_last);
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            @(posedge clk); #1;
            if (pv && pr && pl) begin
                got_last = 1'b1;
                break;
            end
        end
        rd_ready = 1'b0;
        adc_valid = 1'b0;
        trig = 1'b0;
        if (first_pop >= 0) span = last_pop - first_pop + 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got=%b exp=0", rd_last); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        checks++; if (trig_addr !== '0) begin errors++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit sv, gl;
        int sb, sp, t, lw;
        trig_list = '{20};
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_arm got=%b exp=1", busy); end
        feed(0, 1, 1'b0, 1'b0, 0, sv);
        checks++; if (!sv) begin errors++; $display("FAIL basic_rd_valid_timeout got=0 exp=1"); end
        t = model_frame();
        lw = t + DEPTH - PRETRIG - 1;
        checks++; if (trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL basic_trig_addr got=%0d exp=%0d", trig_addr, t % DEPTH); end
        checks++;
        if (lw >= cyc_q.size() || first_valid_cyc - cyc_q[lw] > 3) begin
            errors++; $display("FAIL basic_read_latency got=%0d exp<=3", first_valid_cyc - ((lw < cyc_q.size()) ? cyc_q[lw] : 0));
        end
        drain(1'b0, 0, gl, sb, sp);
        checks++; if (!gl) begin errors++; $display("FAIL basic_last_seen got=0 exp=1"); end
        checks++; if (sp != DEPTH) begin errors++; $display("FAIL basic_no_bubble_span got=%0d exp=%0d", sp, DEPTH); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
            checks++; if (last_q[i] !== (i == DEPTH - 1)) begin errors++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, last_q[i], i == DEPTH - 1); end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b/%b exp=1/0", done, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_fill_mask();
        bit sv, gl;
        int sb, sp, t;
        trig_list = '{0, 1, 2, 3, 9};
        do_arm();
        feed(0, 1, 1'b0, 1'b0, 0, sv);
        t = model_frame();
        checks++; if (trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL fill_trig_addr got=%0d exp=%0d", trig_addr, t % DEPTH); end
        drain(1'b0, 0, gl, sb, sp);
        checks++; if (got_q.size() != exp_q.size() || !gl) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit sv, gl;
        int sb, sp, t;
        trig_list = '{20};
        do_arm();
        feed(0, 1, 1'b0, 1'b0, 0, sv);
        t = model_frame();
        checks++; if (trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL bp_trig_addr got=%0d exp=%0d", trig_addr, t % DEPTH); end
        drain(1'b1, 0, gl, sb, sp);
        checks++; if (sb != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", sb); end
        checks++; if (got_q.size() != exp_q.size() || !gl) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
            checks++; if (last_q[i] !== (i == DEPTH - 1)) begin errors++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, last_q[i], i == DEPTH - 1); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gapped();
        bit sv, gl;
        int sb, sp, t;
        trig_list = '{30};
        do_arm();
        feed(0, 3, 1'b0, 1'b1, 0, sv);
        t = model_frame();
        checks++; if (trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL gap_trig_addr got=%0d exp=%0d", trig_addr, t % DEPTH); end
        drain(1'b0, 0, gl, sb, sp);
        checks++; if (got_q.size() != exp_q.size() || !gl) begin errors++; $display("FAIL gap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort_rearm();
        bit sv, gl;
        int sb, sp, t;
        trig_list = '{20};
        do_arm();
        feed(0, 1, 1'b0, 1'b0, 0, sv);
        void'(model_frame());
        drain(1'b0, 5, gl, sb, sp);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL abort_partial_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_partial[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b/%b exp=0/0", rd_valid, busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", done); end
        trig_list = '{10};
        do_arm();
        feed(40, 1, 1'b0, 1'b0, 0, sv);
        t = model_frame();
        checks++; if (trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL rearm_trig_addr got=%0d exp=%0d", trig_addr, t % DEPTH); end
        drain(1'b0, 0, gl, sb, sp);
        checks++; if (got_q.size() != exp_q.size() || !gl) begin errors++; $display("FAIL rearm_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rearm_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_post();
        bit sv, gl;
        int sb, sp, t;
        trig_list = '{20};
        do_arm();
        feed(0, 1, 1'b0, 1'b0, 24, sv);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got=%b/%b exp=0/0", busy, done); end
        checks++; if (trig_addr !== '0) begin errors++; $display("FAIL rst_trig_addr got=%0d exp=0", trig_addr); end
        checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL rst_read_outputs got=%b/%b/%0d exp=0/0/0", rd_valid, rd_last, rd_data); end
        @(posedge clk); #1;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
        rst_n = 1'b1;
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_arm_accept got=%b exp=1", busy); end
        feed(0, 1, 1'b0, 1'b0, 0, sv);
        t = model_frame();
        checks++; if (trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL rst_trig_addr2 got=%0d exp=%0d", trig_addr, t % DEPTH); end
        drain(1'b0, 0, gl, sb, sp);
        checks++; if (got_q.size() != exp_q.size() || !gl) begin errors++; $display("FAIL rst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit sv, gl;
        int sb, sp, t, tt;
        for (int it = 0; it < 3; it++) begin
            tt = $urandom_range(PRETRIG, PRETRIG + 24);
            trig_list = {};
            trig_list.push_back($urandom_range(0, PRETRIG - 1));
            trig_list.push_back(tt);
            trig_list.push_back(tt + $urandom_range(1, 5));
            do_arm();
            feed(0, $urandom_range(1, 3), 1'b1, 1'b1, 0, sv);
            t = model_frame();
            checks++; if (t < 0 || trig_addr !== ADDR_W'(t % DEPTH)) begin errors++; $display("FAIL rand%0d_trig_addr got=%0d exp=%0d", it, trig_addr, t % DEPTH); end
            drain(1'b1, 0, gl, sb, sp);
            checks++; if (sb != 0) begin errors++; $display("FAIL rand%0d_stall_stable got=%0d exp=0", it, sb); end
            checks++; if (got_q.size() != exp_q.size() || !gl) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got=%0d exp=%0d", it, i, got_q[i], exp_q[i]); end
            end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand%0d_done got=%b exp=1", it, done); end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_fill_mask();
        test_backpressure();
        test_gapped();
        test_abort_rearm();
        test_reset_mid_post();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
